// File: rtl/flex_updown_counter.sv
// Programmable up/down counter with parallel load, one-shot stop and a
// saturating wrap-event counter. All outputs are registered.
module flex_updown_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int WRAP_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_up,
    input  logic                    one_shot,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    done,
    output logic [WRAP_BITS-1:0]    wrap_count
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = NUM_CNT_BITS'(1);
    localparam logic [WRAP_BITS-1:0]    WRAP_ONE = WRAP_BITS'(1);
    localparam logic [WRAP_BITS-1:0]    WRAP_MAX = '1;

    logic                    rv_zero;
    logic                    at_wrap;
    logic [NUM_CNT_BITS-1:0] term_val;
    logic [NUM_CNT_BITS-1:0] step_val;

    // Out-of-range counts fall into the wrap branch through >= / <=.
    always_comb begin
        rv_zero  = (rollover_val == '0);
        term_val = count_up ? rollover_val : CNT_ONE;
        at_wrap  = count_up ? (count_out >= rollover_val) : (count_out <= CNT_ONE);
        step_val = count_out;
        if (count_up)
            step_val = at_wrap ? CNT_ONE : count_out + CNT_ONE;
        else
            step_val = at_wrap ? rollover_val : count_out - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
            done          <= 1'b0;
            wrap_count    <= '0;
        end else if (load) begin
            count_out     <= load_val;
            rollover_flag <= !rv_zero && (load_val == term_val);
            done          <= 1'b0;
        end else if (count_enable && !done) begin
            if (rv_zero) begin
                rollover_flag <= 1'b0;
            end else if (one_shot && at_wrap) begin
                // Terminal step in one-shot mode: hold the count, not a wrap.
                done          <= 1'b1;
                rollover_flag <= (count_out == term_val);
            end else begin
                count_out     <= step_val;
                rollover_flag <= (step_val == term_val);
                if (at_wrap && wrap_count != WRAP_MAX)
                    wrap_count <= wrap_count + WRAP_ONE;
            end
        end
    end

endmodule

// File: doc/flex_updown_counter.md
# flex_updown_counter

Parametrised successor to the team's up-only flex counter. Adds a configurable width, runtime up/down direction, synchronous parallel load, a one-shot (stop-at-terminal) mode and a saturating wrap-event counter. It serves as the general-purpose programmable counter for timers, bit/byte counters and baud/tick generators in the lab datapaths. Every output is registered.

## Interface
- NUM_CNT_BITS, 4, width of count_out, rollover_val, load_val (≥2)
- WRAP_BITS, 8, width of wrap_count (≥1)
- clk  in  1  rising-edge clock
- n_rst  in  1  synchronous, active-low reset
- clear  in  1  synchronous clear of count, flags and wrap_count
- load  in  1  parallel load of load_val
- load_val  in  NUM_CNT_BITS  value loaded when load=1
- count_enable  in  1  advance one step this cycle
- count_up  in  1  direction: 1 = up, 0 = down
- one_shot  in  1  1 = stop at terminal value instead of wrapping
- rollover_val  in  NUM_CNT_BITS  terminal value (up) / reload value (down)
- count_out  out  NUM_CNT_BITS  current count
- rollover_flag  out  1  count_out is at the terminal value for the current direction
- done  out  1  sticky: one-shot terminal reached and held
- wrap_count  out  WRAP_BITS  number of wrap events, saturating

## Operation
- Priority at each rising edge: n_rst=0 > clear > load > count_enable > hold.
- Terminal value: rollover_val when count_up=1; 1 when count_up=0.
- Up step:
  - If count_out ≥ rollover_val, next = 1 (wrap event).
  - Otherwise next = count_out+1.
- Down step:
  - If count_out ≤ 1, next = rollover_val (wrap event).
  - Otherwise next = count_out−1.
- rollover_val = 0 is a degenerate configuration:
  - count_enable has no effect on count_out.
  - rollover_flag is forced 0.
  - No wrap events occur.
  - load and clear still act.
- One-shot (one_shot=1):
  - An enabled step from the terminal value does not wrap.
  - count_out holds and done sets to 1; this is not a wrap event.
  - While done=1, enable is ignored.
  - done clears only on clear, load or reset.
- wrap_count:
  - Increments by 1 per wrap event.
  - Saturates at 2^WRAP_BITS−1.
  - Clears on clear or reset; unaffected by load.
- rollover_flag is registered. It equals (next count == terminal value), evaluated with the count_up sampled on the same edge. It is 0 when rollover_val = 0.
  - rollover_flag does not update on a direction change alone, without a step, load or clear. It refreshes on the next edge on which any of those occur.
- Load:
  - count_out = load_val, taken unclamped.
  - rollover_flag is computed from load_val.
  - done clears.
- Clear:
  - count_out = 0, rollover_flag = 0, done = 0, wrap_count = 0.
  - Takes effect even if load or count_enable is also asserted.
- Arithmetic is unsigned, NUM_CNT_BITS wide. No binary overflow is reachable in the up direction, because the ≥ compare wraps first.

## Timing
- Reset values (n_rst=0 sampled at an edge): count_out=0, rollover_flag=0, done=0, wrap_count=0.
- Reset is synchronous. n_rst going low between edges changes nothing until the next rising edge. Reset asserted mid-count zeroes all state on that edge.
- Latency is 1 cycle from sampled inputs to outputs. Each enabled cycle makes exactly one step.
- rollover_flag rises in the same cycle that count_out reaches the terminal value. It falls on the cycle the counter leaves it.
- done rises on the edge where the one-shot terminal step is attempted. count_out is unchanged on that edge.
- Changing rollover_val mid-count takes effect on the next step. The ≥ / ≤ rules govern out-of-range counts.

## Test plan
- Up wrap:
  - Stimulus: reset, rollover_val=5, count_up=1, enable held 12 cycles.
  - Response: count_out 1,2,3,4,5,1,2,3,4,5,1,2; rollover_flag high exactly while count_out=5; wrap_count=2.
- Down wrap:
  - Stimulus: load_val=3, rollover_val=4, count_up=0, enable 6 cycles.
  - Response: 2,1,4,3,2,1; flag high at each 1; wrap_count=1.
- Priority:
  - Stimulus: clear=load=enable=1 with load_val=9 → count_out=0, wrap_count=0.
  - Next: load=enable=1 with load_val=9 → count_out=9, not 10.
  - Next: load=1, load_val=7, rollover_val=7, up → flag=1 on the load cycle.
- One-shot:
  - Stimulus: one_shot=1, rollover_val=3, up from 0, enable 6 cycles.
  - Response: 1,2,3,3,3,3; done=1 from the 4th cycle; wrap_count=0.
  - Then load_val=0 → done=0, count_out=0.
- Saturation and degenerate configuration:
  - Stimulus: WRAP_BITS=2, rollover_val=1, up, enable 10 cycles.
  - Response: wrap_count stops at 3.
  - Then rollover_val=0 with enable → count_out frozen, rollover_flag=0.
- Reset:
  - Stimulus: n_rst low for half a cycle between edges mid-count.
  - Response: no change; then n_rst low across an edge → all outputs 0 on that edge.
  - Stimulus: count_up toggled mid-count at count_out=4, rollover_val=6.
  - Response: next step gives 3.
